// File: rtl/exception_commit_pkg.sv
// Shared CPU defines for the exception/commit path.
//   - ExcCode values written into Cause.ExcCode
//   - CP0 register numbers used by MTC0/MFC0
//   - bit positions inside MEM_ExcVec
//   - commit FSM state encoding and the resolved-exception record
package exception_commit_pkg;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_SYS  = 5'd8;
    localparam logic [4:0] EXC_BP   = 5'd9;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;
    localparam logic [4:0] EXC_TR   = 5'd13;

    localparam logic [4:0] CP0_BADVADDR = 5'd8;
    localparam logic [4:0] CP0_COUNT    = 5'd9;
    localparam logic [4:0] CP0_COMPARE  = 5'd11;
    localparam logic [4:0] CP0_STATUS   = 5'd12;
    localparam logic [4:0] CP0_CAUSE    = 5'd13;
    localparam logic [4:0] CP0_EPC      = 5'd14;

    localparam int EV_ADEL_IF = 0;
    localparam int EV_RI      = 1;
    localparam int EV_OV      = 2;
    localparam int EV_TR      = 3;
    localparam int EV_SYS     = 4;
    localparam int EV_BP      = 5;
    localparam int EV_ADEL_D  = 6;
    localparam int EV_ADES    = 7;
    localparam int EV_RSVD    = 8;

    typedef enum logic {
        S_IDLE     = 1'b0,
        S_REDIRECT = 1'b1
    } state_t;

    // Outcome of priority resolution for the MEM-stage instruction.
    typedef struct packed {
        logic       hit;      // some exception (or interrupt) is taken
        logic [4:0] code;     // Cause.ExcCode to record
        logic       badv_en;  // BadVAddr gets written
        logic       badv_pc;  // BadVAddr source is the PC (fetch fault)
    } exc_t;

endpackage

// File: rtl/exception_commit_cp0.sv
// cp0_regs: CP0 register file (BadVAddr, Count, Compare, Status, Cause, EPC).
// Ports:
//   clk, rst                       clock, async active-high reset
//   ext_int[5:0]                   level interrupts -> Cause.IP[7:2]
//   wr_en/wr_addr/wr_data          MTC0 write (already qualified by the commit logic)
//   rd_addr/rd_data                combinational MFC0 read
//   exc_commit/exc_code/exc_bd/exc_pc  exception side effects
//   badv_en/badv_data              BadVAddr update on address faults
//   eret                           clears Status.EXL
//   int_req                        pending enabled interrupt
//   epc                            current EPC (ERET target)
module cp0_regs
    import exception_commit_pkg::*;
#(
    parameter int COUNT_DIV = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  ext_int,
    input  logic        wr_en,
    input  logic [4:0]  wr_addr,
    input  logic [31:0] wr_data,
    input  logic [4:0]  rd_addr,
    output logic [31:0] rd_data,
    input  logic        exc_commit,
    input  logic [4:0]  exc_code,
    input  logic        exc_bd,
    input  logic [31:0] exc_pc,
    input  logic        badv_en,
    input  logic [31:0] badv_data,
    input  logic        eret,
    output logic        int_req,
    output logic [31:0] epc
);
    localparam int DW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;

    logic [7:0]    im;
    logic          exl, ie, bd, ti;
    logic [1:0]    sw_ip;
    logic [4:0]    exc_code_q;
    logic [31:0]   badvaddr, count, compare;
    logic [DW-1:0] div;
    logic [7:0]    ip;
    logic [31:0]   status, cause;
    logic          wr_status, wr_cause, wr_epc, wr_count, wr_compare;

    assign wr_status  = wr_en && (wr_addr == CP0_STATUS);
    assign wr_cause   = wr_en && (wr_addr == CP0_CAUSE);
    assign wr_epc     = wr_en && (wr_addr == CP0_EPC);
    assign wr_count   = wr_en && (wr_addr == CP0_COUNT);
    assign wr_compare = wr_en && (wr_addr == CP0_COMPARE);

    // Timer interrupt shares IP7 with the top external line.
    assign ip      = {ext_int[5] | ti, ext_int[4:0], sw_ip};
    assign status  = {9'd0, 1'b1, 6'd0, im, 6'd0, exl, ie};
    assign cause   = {bd, ti, 14'd0, ip, 1'b0, exc_code_q, 2'd0};
    assign int_req = ie && !exl && (|(ip & im));

    // Exception side effects are applied after MTC0 so they win on the same
    // register; ERET last so its EXL clear is final.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            im         <= '0;
            exl        <= 1'b0;
            ie         <= 1'b0;
            bd         <= 1'b0;
            sw_ip      <= '0;
            exc_code_q <= '0;
            epc        <= '0;
            badvaddr   <= '0;
        end else begin
            if (wr_status) begin
                im  <= wr_data[15:8];
                exl <= wr_data[1];
                ie  <= wr_data[0];
            end
            if (wr_cause) sw_ip <= wr_data[9:8];
            if (wr_epc)   epc   <= wr_data;
            if (exc_commit) begin
                exc_code_q <= exc_code;
                exl        <= 1'b1;
                // Nested exceptions keep the original return point.
                if (!exl) begin
                    epc <= exc_bd ? exc_pc - 32'd4 : exc_pc;
                    bd  <= exc_bd;
                end
                if (badv_en) badvaddr <= badv_data;
            end
            if (eret) exl <= 1'b0;
        end
    end

    // Count advances once per COUNT_DIV cycles; a Count write restarts the phase.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count   <= '0;
            compare <= '0;
            div     <= '0;
            ti      <= 1'b0;
        end else begin
            if (wr_count) begin
                count <= wr_data;
                div   <= '0;
            end else if (div == DW'(COUNT_DIV - 1)) begin
                count <= count + 32'd1;
                div   <= '0;
            end else begin
                div <= div + 1'b1;
            end
            if (wr_compare) begin
                compare <= wr_data;
                ti      <= 1'b0;
            end else if (count == compare) begin
                ti <= 1'b1;
            end
        end
    end

    always_comb begin
        rd_data = '0;
        case (rd_addr)
            CP0_BADVADDR: rd_data = badvaddr;
            CP0_COUNT:    rd_data = count;
            CP0_COMPARE:  rd_data = compare;
            CP0_STATUS:   rd_data = status;
            CP0_CAUSE:    rd_data = cause;
            CP0_EPC:      rd_data = epc;
            default:      rd_data = '0;
        endcase
    end

endmodule

// File: rtl/exception_commit.sv
// exception_commit: resolves MEM-stage exceptions/interrupts/ERET, updates CP0,
// flushes the pipe and redirects fetch through a valid/ready handshake.
// Ports:
//   clk, rst                       clock, async active-high reset
//   MEM_*                          committing instruction info
//   Ext_Int[5:0]                   external interrupt levels
//   CP0_Wr*/CP0_Rd*                MTC0 write / MFC0 read ports
//   Flush                          one-cycle kill of IF..MEM after a commit
//   Redirect_Valid/PC/Ready        fetch redirect handshake
module exception_commit
    import exception_commit_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = 32'hBFC00380,
    parameter int          COUNT_DIV  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MEM_Valid,
    input  logic [31:0] MEM_PC,
    input  logic        MEM_InDelaySlot,
    input  logic [8:0]  MEM_ExcVec,
    input  logic [31:0] MEM_BadVAddr,
    input  logic        MEM_Eret,
    input  logic [5:0]  Ext_Int,
    input  logic        CP0_WrEn,
    input  logic [4:0]  CP0_WrAddr,
    input  logic [31:0] CP0_WrData,
    input  logic [4:0]  CP0_RdAddr,
    output logic [31:0] CP0_RdData,
    output logic        Flush,
    output logic        Redirect_Valid,
    output logic [31:0] Redirect_PC,
    input  logic        Redirect_Ready
);
    state_t      state, state_nx;
    exc_t        exc;
    logic        int_req, accept, exc_commit, eret_commit, mtc0;
    logic [31:0] epc;
    logic        unused_resv;

    assign unused_resv = MEM_ExcVec[EV_RSVD];

    // MEM is only looked at while no redirect is outstanding.
    assign accept      = MEM_Valid && (state == S_IDLE);
    assign exc_commit  = accept && exc.hit;
    assign eret_commit = accept && MEM_Eret && !exc.hit;
    assign mtc0        = accept && CP0_WrEn && !exc.hit;

    always_comb begin
        exc = '{hit: 1'b1, code: EXC_INT, badv_en: 1'b0, badv_pc: 1'b0};
        if (int_req)                    exc.code = EXC_INT;
        else if (MEM_ExcVec[EV_ADEL_IF]) begin
            exc.code    = EXC_ADEL;
            exc.badv_en = 1'b1;
            exc.badv_pc = 1'b1;
        end
        else if (MEM_ExcVec[EV_RI])     exc.code = EXC_RI;
        else if (MEM_ExcVec[EV_OV])     exc.code = EXC_OV;
        else if (MEM_ExcVec[EV_TR])     exc.code = EXC_TR;
        else if (MEM_ExcVec[EV_SYS])    exc.code = EXC_SYS;
        else if (MEM_ExcVec[EV_BP])     exc.code = EXC_BP;
        else if (MEM_ExcVec[EV_ADEL_D]) begin
            exc.code    = EXC_ADEL;
            exc.badv_en = 1'b1;
        end
        else if (MEM_ExcVec[EV_ADES]) begin
            exc.code    = EXC_ADES;
            exc.badv_en = 1'b1;
        end
        else                            exc.hit = 1'b0;
    end

    cp0_regs #(.COUNT_DIV(COUNT_DIV)) u_cp0 (
        .clk        (clk),
        .rst        (rst),
        .ext_int    (Ext_Int),
        .wr_en      (mtc0),
        .wr_addr    (CP0_WrAddr),
        .wr_data    (CP0_WrData),
        .rd_addr    (CP0_RdAddr),
        .rd_data    (CP0_RdData),
        .exc_commit (exc_commit),
        .exc_code   (exc.code),
        .exc_bd     (MEM_InDelaySlot),
        .exc_pc     (MEM_PC),
        .badv_en    (exc.badv_en),
        .badv_data  (exc.badv_pc ? MEM_PC : MEM_BadVAddr),
        .eret       (eret_commit),
        .int_req    (int_req),
        .epc        (epc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:     if (exc_commit || eret_commit) state_nx = S_REDIRECT;
            S_REDIRECT: if (Redirect_Ready)            state_nx = S_IDLE;
            default:    state_nx = S_IDLE;
        endcase
    end

    // Decoded from the state register so reset drops it without a clock.
    assign Redirect_Valid = (state == S_REDIRECT);

    // Redirect_PC only loads from IDLE, so it is frozen for the whole REDIRECT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Flush       <= 1'b0;
            Redirect_PC <= '0;
        end else begin
            Flush <= exc_commit || eret_commit;
            if (exc_commit)       Redirect_PC <= EXC_VECTOR;
            else if (eret_commit) Redirect_PC <= epc;
        end
    end

endmodule

// File: doc/exception_commit.md
EXCEPTION_COMMIT -- requirements
Module: exception_commit

Interface
REQ-001 SHALL have parameter EXC_VECTOR, default 32'hBFC00380, the exception entry PC.
REQ-002 SHALL have parameter COUNT_DIV, default 2, the number of clk cycles per Count increment.
REQ-003 SHALL have port clk  in  1  the single clock; all state changes on the rising edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous and active-high.
REQ-005 SHALL have port MEM_Valid  in  1  the MEM-stage instruction is valid and committing.
REQ-006 SHALL have port MEM_PC  in  32  PC of the MEM-stage instruction.
REQ-007 SHALL have port MEM_InDelaySlot  in  1  the instruction sits in a branch delay slot.
REQ-008 SHALL have port MEM_ExcVec  in  9  one-hot-or-more flags, bit 0 to bit 8: AdEL-fetch, RI, Ov, Trap, Sys, Bp, AdEL-data, AdES, reserved (0).
REQ-009 SHALL have port MEM_BadVAddr  in  32  faulting data address.
REQ-010 SHALL have port MEM_Eret  in  1  the instruction is ERET.
REQ-011 SHALL have port Ext_Int  in  6  level-sensitive external interrupts mapped to Cause.IP[7:2].
REQ-012 SHALL have port CP0_WrEn / CP0_WrAddr / CP0_WrData  in  1/5/32  MTC0 write port, qualified by MEM_Valid.
REQ-013 SHALL have port CP0_RdAddr / CP0_RdData  in 5 / out 32  combinational MFC0 read port.
REQ-014 SHALL have port Flush  out  1  one-cycle pulse that kills IF through MEM.
REQ-015 SHALL have port Redirect_Valid / Redirect_PC / Redirect_Ready  out 1 / out 32 / in 1  fetch-redirect handshake.

Function
REQ-016 SHALL implement the CP0 registers BadVAddr(8), Count(9), Compare(11), Status(12), Cause(13) and EPC(14); reads of any other address SHALL return 0.
REQ-017 SHALL raise an interrupt request when Status.IE=1, Status.EXL=0 and (Cause.IP & Status.IM)!=0.
REQ-018 SHALL resolve exception priority as Int > AdEL-fetch > RI > Ov > Trap > Sys > Bp > AdEL-data > AdES.
REQ-019 SHALL use ExcCode values Int 0, AdEL 4, AdES 5, Sys 8, Bp 9, RI 10, Ov 12, Tr 13.
REQ-020 SHALL commit an exception only when MEM_Valid=1 and the FSM is in IDLE.
REQ-021 On commit, SHALL in the same edge:
  - write Cause.ExcCode;
  - set Status.EXL;
  - if EXL was 0, write EPC = InDelaySlot ? PC-4 : PC and set Cause.BD = InDelaySlot;
  - for AdEL-fetch, write BadVAddr = PC; for AdEL/AdES-data, write BadVAddr = MEM_BadVAddr.
REQ-022 On commit, SHALL pulse Flush for exactly one cycle, in the cycle after the commit edge.
REQ-023 On an exception commit, SHALL assert Redirect_Valid with Redirect_PC=EXC_VECTOR, again in the cycle after the commit edge.
REQ-024 ERET with MEM_Valid, in IDLE and with no higher exception, SHALL clear EXL, pulse Flush, and redirect to the pre-clear EPC.
REQ-025 FSM states: IDLE and REDIRECT.
  - IDLE->REDIRECT on an exception or ERET commit.
  - REDIRECT->IDLE on the cycle where Redirect_Valid and Redirect_Ready are both 1.
REQ-026 SHALL hold Redirect_Valid and Redirect_PC stable in REDIRECT until Redirect_Ready; MEM inputs SHALL be ignored in REDIRECT.
REQ-027 An MTC0 in the same cycle as an exception on that instruction SHALL be suppressed; an exception commit SHALL win over a simultaneous MTC0 to the same register.
REQ-028 Count SHALL increment every COUNT_DIV cycles and wrap from 32'hFFFFFFFF to 0.
REQ-029 Cause.TI (IP7) SHALL be set when Count==Compare, and cleared by an MTC0 to Compare.
REQ-030 Writable fields SHALL be limited to:
  - Status IM[15:8], EXL[1], IE[0];
  - Cause IP[1:0];
  - EPC, Count and Compare fully.
  All other bits SHALL read 0, except Status.BEV (bit 22), which SHALL read 1.

Reset
REQ-031 On rst, SHALL clear the following: Status to 32'h00400000, Cause, EPC, BadVAddr, Count and Compare to 0, the FSM to IDLE, and Flush and Redirect_Valid to 0.
REQ-032 rst asserted in REDIRECT SHALL drop Redirect_Valid immediately (asynchronously).

Structure
REQ-033 The ExcCode constants, CP0 register addresses, the MEM_ExcVec bit positions and the FSM state enum SHALL live in the shared CPU defines package.
REQ-034 The CP0 register file with Count/Compare SHALL be a sub-module named cp0_regs; priority encoding and the FSM SHALL remain in exception_commit.

Verification
REQ-035 Trap commit: MEM_ExcVec[3]=1, PC=32'h80001004, not in a delay slot -> EPC=32'h80001004, ExcCode=13, EXL=1, one Flush pulse, Redirect_PC=32'hBFC00380.
REQ-036 Delay-slot Ov: PC=32'h80002008, InDelaySlot=1, ExcVec[2]=1 -> EPC=32'h80002004, BD=1, ExcCode=12.
REQ-037 Redirect_Ready held 0 for 3 cycles with a new Sys arriving meanwhile -> Redirect_Valid/PC stable, Sys ignored, return to IDLE on the first Ready=1.
REQ-038 Count/Compare: write Compare=10, Count=0, Status=32'h00408001 -> interrupt commit (ExcCode 0) at the first valid MEM instruction after Count reaches 10; MTC0 Compare clears TI.
REQ-039 ERET with EPC=32'h80003000 and EXL=1 -> EXL=0, Flush pulse, Redirect_PC=32'h80003000; a second exception with EXL=1 keeps EPC unchanged.
REQ-040 rst asserted in REDIRECT -> Redirect_Valid=0 and Status=32'h00400000 with no clock edge.
